// File: rtl/xchg_regfile_pkg.sv
// Shared definitions for the exchange register file: default geometry and
// the sequencer state encoding (IDLE=0, READ=1, WRA=2, WRB=3, DONE=4).
package xchg_regfile_pkg;

    localparam int XCHG_WIDTH = 8;
    localparam int XCHG_DEPTH = 4;
    localparam int XCHG_AW    = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WRA  = 3'd2,
        ST_WRB  = 3'd3,
        ST_DONE = 3'd4
    } xchg_state_e;

endpackage

// File: rtl/xchg_regfile_mem.sv
// DEPTHxWIDTH register storage.
//   clk_i/rst_i            : clock, synchronous active-high reset (clears all)
//   we_i/waddr_i/wdata_i   : single synchronous write port
//   raddr_i/rdata_o        : registered read port, 1-cycle latency; a same-edge
//                            write to the same index returns the old value
//   ra_addr_i/ra_data_o,
//   rb_addr_i/rb_data_o    : combinational read ports for the exchange READ
module xchg_regfile_mem
    import xchg_regfile_pkg::*;
#(
    parameter int WIDTH = XCHG_WIDTH,
    parameter int DEPTH = XCHG_DEPTH,
    parameter int AW    = XCHG_AW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic [AW-1:0]    ra_addr_i,
    output logic [WIDTH-1:0] ra_data_o,
    input  logic [AW-1:0]    rb_addr_i,
    output logic [WIDTH-1:0] rb_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o   = rdata_q;
    assign ra_data_o = mem_q[ra_addr_i];
    assign rb_data_o = mem_q[rb_addr_i];

endmodule

// File: rtl/xchg_regfile.sv
// Four-entry register file with an exchange sequencer driving an external
// combinational swap stage (swap_a/swap_b out, swap_ya/swap_yb back in).
//   CLK/RST          : clock, synchronous active-high reset
//   req/ra/rb        : start exchange of regs[ra] and regs[rb] (IDLE only)
//   busy/ack         : busy outside IDLE; ack pulses in DONE
//   swap_a/swap_b    : operands latched in READ, held otherwise
//   swap_ya/swap_yb  : swap results, written back in WRA/WRB
//   wr_en/wr_addr/wr_data : external write port (IDLE only)
//   rd_addr/rd_data  : registered read port, 1-cycle latency
module xchg_regfile
    import xchg_regfile_pkg::*;
#(
    parameter int WIDTH = XCHG_WIDTH,
    parameter int DEPTH = XCHG_DEPTH,
    parameter int AW    = XCHG_AW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic             busy,
    output logic             ack,
    output logic [WIDTH-1:0] swap_a,
    output logic [WIDTH-1:0] swap_b,
    input  logic [WIDTH-1:0] swap_ya,
    input  logic [WIDTH-1:0] swap_yb,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    xchg_state_e      state_q, state_d;
    logic [AW-1:0]    ra_q, rb_q;
    logic [WIDTH-1:0] swap_a_q, swap_b_q;
    logic [WIDTH-1:0] rd_a, rd_b;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            swap_a_q <= '0;
            swap_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                ra_q <= ra;
                rb_q <= rb;
            end
            // Storage already holds any write from the accepting edge here.
            if (state_q == ST_READ) begin
                swap_a_q <= rd_a;
                swap_b_q <= rd_b;
            end
        end
    end

    // Next state plus the write-port mux: external port in IDLE, swap
    // results in WRA/WRB, nothing elsewhere.
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        waddr   = wr_addr;
        wdata   = wr_data;
        case (state_q)
            ST_IDLE: begin
                we = wr_en;
                if (req) state_d = ST_READ;
            end
            ST_READ: state_d = ST_WRA;
            ST_WRA: begin
                we      = 1'b1;
                waddr   = ra_q;
                wdata   = swap_ya;
                state_d = ST_WRB;
            end
            ST_WRB: begin
                we      = 1'b1;
                waddr   = rb_q;
                wdata   = swap_yb;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    xchg_regfile_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_i     (CLK),
        .rst_i     (RST),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_i   (rd_addr),
        .rdata_o   (rd_data),
        .ra_addr_i (ra_q),
        .ra_data_o (rd_a),
        .rb_addr_i (rb_q),
        .rb_data_o (rd_b)
    );

    assign busy   = (state_q != ST_IDLE);
    assign ack    = (state_q == ST_DONE);
    assign swap_a = swap_a_q;
    assign swap_b = swap_b_q;

endmodule
